// File: rtl/lfsr_arbiter_pkg.sv
// lfsr_arbiter_pkg: shared types and LFSR step/seed helpers for lfsr_arbiter.
// LFSR_ARBITER_AUG_EN selects the 16-state augmented sequence that includes 0000.
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GEN} state_t;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 4'h1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
`ifdef LFSR_ARBITER_AUG_EN
        return {(~(s[3] | s[2] | s[1]) ^ s[0]) ^ s[3], s[3], s[2], s[1]};
`else
        return {s[1] ^ s[0], s[3], s[2], s[1]};
`endif
    endfunction

    // The plain sequence locks up at zero, so a zero seed is substituted there.
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] v);
`ifdef LFSR_ARBITER_AUG_EN
        return v;
`else
        return (v == '0) ? LFSR_ZERO_SUB : v;
`endif
    endfunction

endpackage

// File: rtl/lfsr_arbiter_if.sv
// lfsr_arbiter_if: request/grant and random-nibble bus of lfsr_arbiter.
interface lfsr_arbiter_if
    import lfsr_pkg::*;
#(
    parameter int N = 4
);
    logic              tick;
    logic [N-1:0]      req;
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic [N-1:0]      gnt;
    logic              rnd_valid;
    logic [LFSR_W-1:0] rnd_data;
    logic              rnd_last;
    logic              busy;

    modport master (
        output tick, req, seed_load, seed,
        input  gnt, rnd_valid, rnd_data, rnd_last, busy
    );

    modport slave (
        input  tick, req, seed_load, seed,
        output gnt, rnd_valid, rnd_data, rnd_last, busy
    );
endinterface

// File: rtl/lfsr_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr with wrap.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          hit
);
    logic [PW-1:0] k;

    always_comb begin
        onehot = '0;
        idx    = '0;
        hit    = 1'b0;
        k      = '0;
        for (int i = 0; i < N; i++) begin
            k = PW'((int'(ptr) + i) % N);
            if (!hit && req[k]) begin
                hit       = 1'b1;
                idx       = k;
                onehot[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin shared 4-bit LFSR delivering BURST nibbles per grant on tick.
// Define LFSR_ARBITER_AUG_EN for the 16-state augmented step with unmodified zero seed.
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int                N           = 4,
    parameter int                BURST       = 4,
    parameter logic [LFSR_W-1:0] RESET_STATE = 4'h1
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N);

    state_t            state, state_n;
    logic [LFSR_W-1:0] s;
    logic [3:0]        count;
    logic [PW-1:0]     ptr, win, pick_idx;
    logic [N-1:0]      win_oh, pick_oh, gnt;
    logic              pick_hit, held, last_step, valid, last;

    rr_arbiter #(.N(N)) u_rr (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .hit    (pick_hit)
    );

    assign held      = |(bus.req & win_oh);
    assign last_step = bus.tick && (count == 4'(BURST - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (!bus.seed_load && pick_hit) ? GRANT : IDLE;
            GRANT:   state_n = held ? GEN : IDLE;
            GEN:     state_n = (!held || last_step) ? IDLE : GEN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            s      <= RESET_STATE;
            count  <= '0;
            ptr    <= '0;
            win    <= '0;
            win_oh <= '0;
            gnt    <= '0;
            valid  <= 1'b0;
            last   <= 1'b0;
        end else begin
            state <= state_n;
            valid <= 1'b0;
            last  <= 1'b0;
            if (state == IDLE && bus.seed_load)
                s <= lfsr_seed(bus.seed);
            if (state == IDLE && pick_hit) begin
                win    <= pick_idx;
                win_oh <= pick_oh;
            end
            if (state == GRANT && held) begin
                gnt   <= win_oh;
                count <= '0;
            end
            // An abort (held low) takes priority over a coincident tick.
            if (state == GEN && held && bus.tick) begin
                s     <= lfsr_next(s);
                count <= count + 4'd1;
                valid <= 1'b1;
                last  <= last_step;
            end
            if (state != IDLE && state_n == IDLE) begin
                gnt <= '0;
                ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rnd_valid = valid;
    assign bus.rnd_data  = s;
    assign bus.rnd_last  = last;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter: directed and randomized bursts checked against a sequence-table reference.
module tb_lfsr_arbiter;
    localparam int N = 4;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    int s_m = 1;
    int ptr_m = 0;
    // Maximal-length x^4+x^3+1 orbit starting from 1.
    int seq[15] = '{1, 8, 4, 2, 9, 12, 6, 11, 5, 10, 13, 14, 15, 7, 3};

    lfsr_arbiter_if #(.N(N)) bus();

    lfsr_arbiter #(.N(N), .BURST(BURST), .RESET_STATE(4'h1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int v);
        for (int i = 0; i < 15; i++)
            if (seq[i] == v) return seq[(i + 1) % 15];
        return -1;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [N-1:0] pat, input int gap, input int abort_at, input bit seed_mid);
        int w;
        int n;
        int g;
        bus.req = pat;
        w = pick(pat, ptr_m);
        n = 0;
        while (bus.gnt == '0 && n < 8) begin
            step();
            n++;
        end
        chk("grant", 32'(bus.gnt), 32'(1 << w));
        chk("busy", 32'(bus.busy), 1);
        for (int v = 0; v < BURST; v++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int c = 0; c < g; c++) begin
                if (seed_mid && c == 0) begin
                    bus.seed_load = 1'b1;
                    bus.seed = 4'($urandom);
                end
                step();
                bus.seed_load = 1'b0;
                chk("gap_valid", 32'(bus.rnd_valid), 0);
            end
            if (v == abort_at) begin
                bus.req[w] = 1'b0;
                step();
                chk("abort_gnt", 32'(bus.gnt), 0);
                chk("abort_valid", 32'(bus.rnd_valid), 0);
                chk("abort_last", 32'(bus.rnd_last), 0);
                chk("abort_busy", 32'(bus.busy), 0);
                ptr_m = (w + 1) % N;
                return;
            end
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            s_m = nxt(s_m);
            chk("data", 32'(bus.rnd_data), 32'(s_m));
            chk("valid", 32'(bus.rnd_valid), 1);
            chk("last", 32'(bus.rnd_last), 32'(v == BURST - 1));
            chk("gnt_hold", 32'(bus.gnt), (v == BURST - 1) ? 0 : 32'(1 << w));
        end
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        logic [N-1:0] pat;
        logic [3:0] sd;
        int n;
        bus.tick = 1'b0;
        bus.req = '0;
        bus.seed_load = 1'b0;
        bus.seed = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'(bus.rnd_data), 1);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_valid", 32'(bus.rnd_valid), 0);
        chk("rst_last", 32'(bus.rnd_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b1;
        step();
        repeat (3) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            chk("idle_tick_data", 32'(bus.rnd_data), 1);
            chk("idle_tick_valid", 32'(bus.rnd_valid), 0);
        end
        bus.seed_load = 1'b1;
        bus.seed = 4'h1;
        step();
        bus.seed_load = 1'b0;
        chk("seed1", 32'(bus.rnd_data), 1);
        burst(4'b0100, 4, -1, 1'b0);
        bus.req = '0;
        step();
        chk("post_gnt", 32'(bus.gnt), 0);
        chk("post_busy", 32'(bus.busy), 0);
        repeat (5) burst(4'hF, -1, -1, 1'b0);
        bus.req = '0;
        step();
        // Put the pointer at 0 so requester 1 wins, abort, then requester 2 must win.
        ptr_m = ptr_m;
        burst(4'b0001, 0, -1, 1'b0);
        bus.req = '0;
        step();
        while (ptr_m != 0) begin
            burst(4'b1111, 0, -1, 1'b0);
            bus.req = '0;
            step();
        end
        burst(4'b0110, 1, 2, 1'b0);
        burst(4'b0100, 1, -1, 1'b0);
        bus.req = '0;
        step();
        bus.seed_load = 1'b1;
        bus.seed = 4'h0;
        step();
        bus.seed_load = 1'b0;
        s_m = 1;
        chk("zero_seed", 32'(bus.rnd_data), 1);
        repeat (4) burst(4'($urandom_range(1, 15)), -1, -1, 1'b0);
        burst(4'($urandom_range(1, 15)), 2, -1, 1'b1);
        repeat (14) begin
            if ($urandom_range(0, 2) == 0) begin
                sd = 4'($urandom);
                bus.seed_load = 1'b1;
                bus.seed = sd;
                step();
                bus.seed_load = 1'b0;
                s_m = (sd == 4'h0) ? 1 : int'(sd);
                chk("rand_seed", 32'(bus.rnd_data), 32'(s_m));
                chk("rand_seed_busy", 32'(bus.busy), 0);
            end
            pat = 4'($urandom_range(1, 15));
            burst(pat, -1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BURST - 1)) : -1, 1'($urandom));
        end
        bus.req = '0;
        step();
        bus.req = 4'b0001;
        n = 0;
        while (bus.gnt == '0 && n < 8) begin
            step();
            n++;
        end
        chk("pre_rst_gnt", 32'(bus.gnt), 32'(1 << pick(4'b0001, ptr_m)));
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_data", 32'(bus.rnd_data), 1);
        chk("mid_rst_gnt", 32'(bus.gnt), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_valid", 32'(bus.rnd_valid), 0);
        bus.req = '0;
        #2 rst = 1'b1;
        s_m = 1;
        ptr_m = 0;
        step();
        burst(4'b1010, 1, -1, 1'b0);
        bus.req = '0;
        step();
        chk("final_busy", 32'(bus.busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_arbiter.md
Name: lfsr_arbiter

Overview:
- Shares one 4-bit pseudorandom generator between N requesters.
- Round-robin grant, seed loading, and burst sequencing: each grant delivers BURST nibbles, one per step tick.
- Sits between the clock divider, which supplies `tick`, and the consumers that need random nibbles.

Parameters:
- N, 4, number of requesters (2..8).
- BURST, 4, nibbles delivered per grant (1..15).
- RESET_STATE, 4'h1, generator state after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- tick  in  1  step enable from the clock divider, single-cycle pulse.
- req  in  N  per-requester request, level; held until `rnd_last` or abort.
- seed_load  in  1  load pulse for `seed`.
- seed  in  4  seed value, msb first.
- gnt  out  N  one-hot grant.
- rnd_valid  out  1  `rnd_data` valid, one cycle.
- rnd_data  out  4  current generator state.
- rnd_last  out  1  marks the final nibble of a burst.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (`rst`=0, async):
  - state=RESET_STATE, FSM=IDLE, rr pointer=0, count=0.
  - `gnt`, `rnd_valid`, `rnd_last`, `busy` all =0; `rnd_data`=RESET_STATE.
- Step function, s[3:0] → s': s' = {s[1]^s[0], s[3], s[2], s[1]} (x^4+x^3+1, period 15).
- `rnd_data` always equals s (registered).
- FSM IDLE:
  - `seed_load`=1 → s<=seed; stay IDLE. `seed_load` has priority over `req` in the same cycle.
  - Else if any `req` → GRANT. Winner = first set bit at or above the rr pointer, with wrap.
- FSM GRANT (1 cycle):
  - Register `gnt` one-hot for the winner; count<=0; → GEN.
  - `gnt` stays asserted throughout GEN.
- FSM GEN, on `tick`:
  - s<=s'; count<=count+1.
  - Next cycle: `rnd_valid`=1, `rnd_data`=new s.
  - On step number BURST, `rnd_last`=1 with that `rnd_valid`.
  - After `rnd_last` → IDLE, `gnt`<=0, rr pointer<=winner+1 mod N.
  - Latency: `tick` to `rnd_valid` is 1 cycle.
  - `tick` while not in GEN: ignored, s holds.
- Abort: granted `req` drops in GRANT or GEN →
  - Next cycle → IDLE, `gnt`<=0, no further `rnd_valid`, no `rnd_last`.
  - rr pointer advances as on completion; s keeps its last value.
- `seed_load` outside IDLE: ignored, no effect.
- Zero seed (feature off): seed 4'h0 is loaded as 4'h1 (lock-up guard).
- Requests arriving during a burst wait; they are re-arbitrated in the IDLE cycle after completion.
- Minimum gap between bursts is 1 IDLE cycle.

Optional Feature:
- Macro: `LFSR_ARBITER_AUG_EN`.
- Defined:
  - Step function = augmented sequence covering 0000: s' = {(~(s[3]|s[2]|s[1]) ^ s[0]) ^ s[3], s[3], s[2], s[1]}. Period 16.
  - Seed 4'h0 is loaded unchanged.
- Undefined:
  - Plain x^4+x^3+1 step (period 15).
  - Zero-seed substitution to 4'h1 as above.

Decomposition:
- Package `lfsr_pkg`:
  - FSM state enum {IDLE, GRANT, GEN}.
  - Width constant `LFSR_W=4`.
  - Function `lfsr_next(s)`, selected by `LFSR_ARBITER_AUG_EN`.
  - Constant `LFSR_ZERO_SUB=4'h1`.
- Sub-module `rr_arbiter`: N-bit round-robin pick given req and pointer; combinational, outputs one-hot and index.
- Top holds the FSM, counter, state register and grant register.

Test Plan:
- Reset with RESET_STATE=1, no req → `rnd_data`=4'h1, all outputs 0; `tick` pulses do not change s.
- `seed_load` seed=4'h1, req[2]=1, BURST=4, ticks every 5 cycles:
  - `gnt`=0100.
  - `rnd_data` on valids = 8, 4, 2, 9; `rnd_last` with 9.
  - Then IDLE, `gnt`=0.
- req=1111 held continuously → grants 0001, 0010, 0100, 1000, 0001 in order; each burst exactly BURST valids.
- req[1] dropped after 2 valids → `gnt` clears next cycle, no `rnd_last`; next grant goes to req[2] when pending.
- `seed_load` 4'h0 in IDLE:
  - Feature off: 15 ticks give period 15 starting 1→8, never 0.
  - `LFSR_ARBITER_AUG_EN` on: seed 4'h1 steps to 0→8, period 16.
- `seed_load` during GEN → ignored, sequence continues; async `rst` low mid-burst → immediate reset values, FSM IDLE.
